// File: rtl/core_pkg.sv
// Shared core definitions: data width, fetch-controller state encoding and
// the branch mispredict test used by the front-end controller.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FC_BOOT = 2'd0,
        FC_RUN  = 2'd1,
        FC_HALT = 2'd2
    } fc_state_t;

    // A taken branch whose predicted target was wrong is also a mispredict.
    function automatic logic is_mispredict(
        input logic            resolved,
        input logic            taken,
        input logic            pred_taken,
        input logic [XLEN-1:0] target,
        input logic [XLEN-1:0] pred_target
    );
        return resolved & ((taken ^ pred_taken) |
                           (taken & pred_taken & (target != pred_target)));
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until the all-ones ceiling.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Pipeline-front controller: arbitrates halt, memory stall, load-use stall and
// branch redirect, drives the BTB update port and keeps performance counters.
module fetch_ctrl
    import core_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_mem_busy,
    input  logic             i_ld_use,
    input  logic             i_br_resolved,
    input  logic             i_br_taken,
    input  logic [XLEN-1:0]  i_br_pc,
    input  logic [XLEN-1:0]  i_br_target,
    input  logic             i_br_pred_taken,
    input  logic [XLEN-1:0]  i_br_pred_target,
    input  logic             i_halt,
    output logic             o_pc_stall,
    output logic             o_ifid_stall,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_btb_update,
    output logic [XLEN-1:0]  o_btb_update_pc,
    output logic [XLEN-1:0]  o_btb_update_target,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_mispred_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int BW = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam fc_state_t RESET_STATE = (BOOT_CYCLES == 0) ? FC_RUN : FC_BOOT;

    fc_state_t   state_r;
    logic [BW-1:0] boot_cnt_r;
    logic        mispredict_s;
    logic        stall_inc_s;
    logic        mispred_inc_s;

    assign mispredict_s = is_mispredict(i_br_resolved, i_br_taken, i_br_pred_taken,
                                        i_br_target, i_br_pred_target);

    // Per-state control decode; RUN applies halt > mem_busy > load-use > mispredict.
    always_comb begin
        o_pc_stall       = 1'b0;
        o_ifid_stall     = 1'b0;
        o_ifid_flush     = 1'b0;
        o_idex_flush     = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        mispred_inc_s    = 1'b0;
        case (state_r)
            FC_BOOT: begin
                o_pc_stall   = 1'b1;
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
            end
            FC_RUN: begin
                if (i_halt) begin
                    o_pc_stall   = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (i_mem_busy) begin
                    o_pc_stall   = 1'b1;
                    o_ifid_stall = 1'b1;
                end else if (i_ld_use) begin
                    o_pc_stall   = 1'b1;
                    o_ifid_stall = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (mispredict_s) begin
                    o_redirect_valid = 1'b1;
                    o_ifid_flush     = 1'b1;
                    mispred_inc_s    = 1'b1;
                    o_redirect_pc    = i_br_taken ? i_br_target : (i_br_pc + 32'd4);
                end else begin
                    o_pc_stall = 1'b0;
                end
            end
            FC_HALT: begin
                o_pc_stall   = 1'b1;
                o_ifid_stall = 1'b1;
                o_idex_flush = 1'b1;
            end
            default: begin
                o_pc_stall = 1'b1;
            end
        endcase
    end

    assign stall_inc_s = (state_r == FC_RUN) && o_pc_stall;
    assign o_halted    = (state_r == FC_HALT);

    // State sequencing: boot warm-up, run, and a halt left only through reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_r    <= RESET_STATE;
            boot_cnt_r <= '0;
        end else begin
            case (state_r)
                FC_BOOT: begin
                    if (boot_cnt_r == BOOT_LAST) begin
                        state_r <= FC_RUN;
                    end else begin
                        boot_cnt_r <= boot_cnt_r + BW'(1);
                    end
                end
                FC_RUN: begin
                    if (i_halt) begin
                        state_r <= FC_HALT;
                    end else begin
                        state_r <= FC_RUN;
                    end
                end
                FC_HALT: state_r <= FC_HALT;
                default: state_r <= FC_HALT;
            endcase
        end
    end

    // Capture taken mispredicts for a one-cycle BTB write on the following cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_btb_update        <= 1'b0;
            o_btb_update_pc     <= '0;
            o_btb_update_target <= '0;
        end else if (o_redirect_valid && i_br_taken) begin
            o_btb_update        <= 1'b1;
            o_btb_update_pc     <= i_br_pc;
            o_btb_update_target <= i_br_target;
        end else begin
            o_btb_update        <= 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk     (i_clk),
        .reset_n (i_reset),
        .inc     (mispred_inc_s),
        .count   (o_mispred_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (i_clk),
        .reset_n (i_reset),
        .inc     (stall_inc_s),
        .count   (o_stall_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a 32-bit-counter instance and a 2-bit-counter
// instance share stimulus; expected outputs are queued per cycle and compared.
module tb_fetch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset, i_mem_busy, i_ld_use, i_br_resolved, i_br_taken;
    logic        i_br_pred_taken, i_halt;
    logic [31:0] i_br_pc, i_br_target, i_br_pred_target;

    logic        pc_stall, ifid_stall, ifid_flush, idex_flush, redir_v, btb_upd, halted;
    logic [31:0] redir_pc, btb_pc, btb_tgt, mcnt, scnt;
    logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_flush, s_redir_v, s_btb_upd, s_halted;
    logic [31:0] s_redir_pc, s_btb_pc, s_btb_tgt;
    logic [1:0]  s_mcnt, s_scnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        pc_stall, ifid_stall, ifid_flush, idex_flush, redir_v, btb_upd, halted;
        logic [31:0] redir_pc, btb_pc, btb_tgt, mcnt, scnt;
        logic [1:0]  mcnt2, scnt2;
    } exp_t;
    exp_t sb[$];

    // Reference model state: 0 boot, 1 run, 2 halt.
    int          m_state, m_boot;
    logic        m_btb_v;
    logic [31:0] m_btb_pc, m_btb_tgt, m_mcnt, m_scnt;
    logic [1:0]  m_mcnt2, m_scnt2;

    always #5 i_clk = ~i_clk;

    fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_mem_busy(i_mem_busy), .i_ld_use(i_ld_use),
        .i_br_resolved(i_br_resolved), .i_br_taken(i_br_taken), .i_br_pc(i_br_pc),
        .i_br_target(i_br_target), .i_br_pred_taken(i_br_pred_taken),
        .i_br_pred_target(i_br_pred_target), .i_halt(i_halt),
        .o_pc_stall(pc_stall), .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush),
        .o_idex_flush(idex_flush), .o_redirect_valid(redir_v), .o_redirect_pc(redir_pc),
        .o_btb_update(btb_upd), .o_btb_update_pc(btb_pc), .o_btb_update_target(btb_tgt),
        .o_halted(halted), .o_mispred_cnt(mcnt), .o_stall_cnt(scnt)
    );

    fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(2)) dut_sat (
        .i_clk(i_clk), .i_reset(i_reset), .i_mem_busy(i_mem_busy), .i_ld_use(i_ld_use),
        .i_br_resolved(i_br_resolved), .i_br_taken(i_br_taken), .i_br_pc(i_br_pc),
        .i_br_target(i_br_target), .i_br_pred_taken(i_br_pred_taken),
        .i_br_pred_target(i_br_pred_target), .i_halt(i_halt),
        .o_pc_stall(s_pc_stall), .o_ifid_stall(s_ifid_stall), .o_ifid_flush(s_ifid_flush),
        .o_idex_flush(s_idex_flush), .o_redirect_valid(s_redir_v), .o_redirect_pc(s_redir_pc),
        .o_btb_update(s_btb_upd), .o_btb_update_pc(s_btb_pc), .o_btb_update_target(s_btb_tgt),
        .o_halted(s_halted), .o_mispred_cnt(s_mcnt), .o_stall_cnt(s_scnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_mem_busy = 1'b0; i_ld_use = 1'b0; i_br_resolved = 1'b0; i_br_taken = 1'b0;
        i_br_pred_taken = 1'b0; i_halt = 1'b0; i_br_pc = 32'h0; i_br_target = 32'h0;
        i_br_pred_target = 32'h0;
    endtask

    task automatic branch(input logic taken, input logic pred, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic [31:0] ptgt);
        i_br_resolved = 1'b1; i_br_taken = taken; i_br_pred_taken = pred;
        i_br_pc = pc; i_br_target = tgt; i_br_pred_target = ptgt;
    endtask

    // One clock cycle: predict outputs, queue them, compare mid-cycle, advance model.
    task automatic step();
        exp_t e, o;
        logic mp, act4, stall_run;
        mp = i_br_resolved && ((i_br_taken != i_br_pred_taken) ||
             (i_br_taken && i_br_pred_taken && (i_br_target != i_br_pred_target)));
        e = '{default: '0};
        act4 = 1'b0;
        if (m_state == 0) begin
            e.pc_stall = 1'b1; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
        end else if (m_state == 2) begin
            e.pc_stall = 1'b1; e.ifid_stall = 1'b1; e.idex_flush = 1'b1;
        end else if (i_halt) begin
            e.pc_stall = 1'b1; e.idex_flush = 1'b1;
        end else if (i_mem_busy) begin
            e.pc_stall = 1'b1; e.ifid_stall = 1'b1;
        end else if (i_ld_use) begin
            e.pc_stall = 1'b1; e.ifid_stall = 1'b1; e.idex_flush = 1'b1;
        end else if (mp) begin
            act4 = 1'b1; e.redir_v = 1'b1; e.ifid_flush = 1'b1;
            e.redir_pc = i_br_taken ? i_br_target : i_br_pc + 32'd4;
        end
        e.btb_upd = m_btb_v; e.btb_pc = m_btb_pc; e.btb_tgt = m_btb_tgt;
        e.halted = (m_state == 2);
        e.mcnt = m_mcnt; e.scnt = m_scnt; e.mcnt2 = m_mcnt2; e.scnt2 = m_scnt2;
        sb.push_back(e);
        stall_run = (m_state == 1) && e.pc_stall;

        @(negedge i_clk);
        o = sb.pop_front();
        chk("pc_stall", {31'b0, pc_stall}, {31'b0, o.pc_stall});
        chk("ifid_stall", {31'b0, ifid_stall}, {31'b0, o.ifid_stall});
        chk("ifid_flush", {31'b0, ifid_flush}, {31'b0, o.ifid_flush});
        chk("idex_flush", {31'b0, idex_flush}, {31'b0, o.idex_flush});
        chk("redirect_valid", {31'b0, redir_v}, {31'b0, o.redir_v});
        chk("redirect_pc", redir_pc, o.redir_pc);
        chk("btb_update", {31'b0, btb_upd}, {31'b0, o.btb_upd});
        chk("btb_pc", btb_pc, o.btb_pc);
        chk("btb_target", btb_tgt, o.btb_tgt);
        chk("halted", {31'b0, halted}, {31'b0, o.halted});
        chk("mispred_cnt", mcnt, o.mcnt);
        chk("stall_cnt", scnt, o.scnt);
        chk("sat_mispred_cnt", {30'b0, s_mcnt}, {30'b0, o.mcnt2});
        chk("sat_stall_cnt", {30'b0, s_scnt}, {30'b0, o.scnt2});

        if (!i_reset) begin
            m_state = 0; m_boot = 0; m_btb_v = 1'b0; m_btb_pc = 32'h0; m_btb_tgt = 32'h0;
            m_mcnt = 32'h0; m_scnt = 32'h0; m_mcnt2 = 2'd0; m_scnt2 = 2'd0;
        end else begin
            if (act4) begin
                m_mcnt = m_mcnt + 32'd1;
                if (m_mcnt2 != 2'd3) m_mcnt2 = m_mcnt2 + 2'd1;
            end
            if (stall_run) begin
                m_scnt = m_scnt + 32'd1;
                if (m_scnt2 != 2'd3) m_scnt2 = m_scnt2 + 2'd1;
            end
            m_btb_v = act4 && i_br_taken;
            if (m_btb_v) begin
                m_btb_pc = i_br_pc; m_btb_tgt = i_br_target;
            end
            if (m_state == 0) begin
                if (m_boot == 1) m_state = 1;
                else m_boot = m_boot + 1;
            end else if (m_state == 1 && i_halt) begin
                m_state = 2;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_and_boot();
        idle(); i_reset = 1'b0; step();
        i_reset = 1'b1; step(); step();
    endtask

    initial begin
        idle();
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        m_state = 0; m_boot = 0; m_btb_v = 1'b0; m_btb_pc = 32'h0; m_btb_tgt = 32'h0;
        m_mcnt = 32'h0; m_scnt = 32'h0; m_mcnt2 = 2'd0; m_scnt2 = 2'd0;
        i_reset = 1'b1;

        // T1: two boot cycles of stall+flush, then quiet run.
        chk("t1_boot_pc_stall", {31'b0, pc_stall}, 32'd1);
        step(); step();
        step();
        chk("t1_run_pc_stall", {31'b0, pc_stall}, 32'd0);
        chk("t1_cnt", mcnt | scnt, 32'd0);

        // T2: taken mispredict redirects and writes the BTB next cycle.
        branch(1'b1, 1'b0, 32'h100, 32'h200, 32'h0);
        step();
        idle();
        chk("t2_btb_update", {31'b0, btb_upd}, 32'd1);
        chk("t2_btb_pc", btb_pc, 32'h100);
        chk("t2_btb_target", btb_tgt, 32'h200);
        chk("t2_mispred_cnt", mcnt, 32'd1);
        step();

        // T3: not-taken mispredict at the top of memory wraps to zero; no BTB write.
        branch(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h40, 32'h40);
        #3;
        chk("t3_redirect_pc", redir_pc, 32'h0);
        chk("t3_redirect_valid", {31'b0, redir_v}, 32'd1);
        step();
        idle();
        chk("t3_btb_update", {31'b0, btb_upd}, 32'd0);
        step();

        // Taken with wrong predicted target, then a correct prediction.
        branch(1'b1, 1'b1, 32'h300, 32'h380, 32'h390); step();
        branch(1'b1, 1'b1, 32'h400, 32'h480, 32'h480); step();
        idle(); step();

        // T4: load-use blocks the branch, which is acted on the next cycle.
        reset_and_boot();
        branch(1'b1, 1'b0, 32'h500, 32'h600, 32'h0);
        i_ld_use = 1'b1; step();
        i_ld_use = 1'b0; step();
        idle();
        chk("t4_mispred_cnt", mcnt, 32'd1);
        chk("t4_stall_cnt", scnt, 32'd1);
        step();

        // T5: mem_busy dominates load-use for three cycles.
        reset_and_boot();
        i_mem_busy = 1'b1; i_ld_use = 1'b1;
        branch(1'b1, 1'b0, 32'h700, 32'h800, 32'h0);
        repeat (3) step();
        idle();
        chk("t5_stall_cnt", scnt, 32'd3);
        step();

        // T6: five mispredicts saturate the 2-bit counter.
        reset_and_boot();
        for (int k = 0; k < 5; k++) begin
            branch(1'b0, 1'b1, 32'h1000 + 32'(k * 4), 32'h0, 32'h0);
            step();
        end
        idle();
        chk("t6_sat_mispred", {30'b0, s_mcnt}, 32'd3);
        chk("t6_full_mispred", mcnt, 32'd5);

        // T6: halt is sticky until reset.
        i_halt = 1'b1; step();
        idle();
        repeat (3) step();
        chk("t6_halted", {31'b0, halted}, 32'd1);

        // T6: reset on the mispredict's edge drops the pending BTB write.
        reset_and_boot();
        branch(1'b1, 1'b0, 32'h900, 32'hA00, 32'h0);
        i_reset = 1'b0; step();
        idle();
        chk("t6_reset_btb", {31'b0, btb_upd}, 32'd0);
        i_reset = 1'b1;
        step(); step(); step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
